// File: rtl/demux_reg_loader_pkg.sv
// Shared defaults and slot geometry for the demux register loader and its matching word mux.
package demux_reg_loader_pkg;

  localparam int unsigned DEF_WORD_LEN    = 8;
  localparam int unsigned DEF_OUTPUT_SIZE = 4;
  localparam int unsigned DEF_SEL_LEN     = 2;

  // LSB of slot i in the packed bus; slot 0 occupies the most-significant word.
  function automatic int unsigned slot_lsb(input int unsigned i,
                                           input int unsigned word_len,
                                           input int unsigned output_size);
    return word_len * (output_size - 1 - i);
  endfunction

endpackage

// File: rtl/demux_reg_loader_slot_decoder.sv
// Combinational slot decoder: select + enable -> one-hot write vector and range flag.
module slot_decoder
  import demux_reg_loader_pkg::*;
#(
  parameter int unsigned output_size = DEF_OUTPUT_SIZE,
  parameter int unsigned sel_len     = DEF_SEL_LEN
) (
  input  logic [sel_len-1:0]     sel_i,
  input  logic                   en_i,
  output logic [output_size-1:0] wr_onehot_c,
  output logic                   in_range_c
);

  always_comb begin
    in_range_c  = (32'(sel_i) < output_size);
    wr_onehot_c = '0;
    for (int unsigned i = 0; i < output_size; i++) begin
      wr_onehot_c[i] = en_i && (sel_i == sel_len'(i));
    end
  end

endmodule

// File: rtl/demux_reg_loader.sv
// Registered word demultiplexer with per-slot valid tracking.
// DEMUX_AUTO_INC_EN selects an internal, non-wrapping slot pointer instead of wr_sel.
module demux_reg_loader
  import demux_reg_loader_pkg::*;
#(
  parameter int unsigned word_len    = DEF_WORD_LEN,
  parameter int unsigned output_size = DEF_OUTPUT_SIZE,
  parameter int unsigned sel_len     = DEF_SEL_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [sel_len-1:0]              wr_sel,
  input  logic [word_len-1:0]             din,
  output logic [word_len*output_size-1:0] demux_out,
  output logic [output_size-1:0]          valid,
  output logic                            full,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned BUS_W = word_len * output_size;

  logic [BUS_W-1:0]       data_q, data_d;
  logic [output_size-1:0] valid_q, valid_d;
  logic                   full_q, full_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [sel_len-1:0]     sel_c;
  logic                   en_c;
  logic                   accept_c;
  logic [output_size-1:0] wr_onehot_c;
  logic                   in_range_c;

`ifdef DEMUX_AUTO_INC_EN
  // ptr_end_q marks the pointer as having passed the last slot; no wrap.
  logic [sel_len-1:0] ptr_q, ptr_d;
  logic               ptr_end_q, ptr_end_d;

  assign sel_c = ptr_q;
  assign en_c  = wr_en && !clear && !ptr_end_q;
`else
  assign sel_c = wr_sel;
  assign en_c  = wr_en && !clear;
`endif

  slot_decoder #(
    .output_size(output_size),
    .sel_len    (sel_len)
  ) u_slot_decoder (
    .sel_i      (sel_c),
    .en_i       (en_c),
    .wr_onehot_c(wr_onehot_c),
    .in_range_c (in_range_c)
  );

  assign accept_c = en_c && in_range_c;

  // Next-state: slot writes, clear override, then derived flags and pulses.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int unsigned i = 0; i < output_size; i++) begin
      if (accept_c && wr_onehot_c[i]) begin
        data_d[slot_lsb(i, word_len, output_size) +: word_len] = din;
        valid_d[i] = 1'b1;
      end
    end
    if (clear) begin
      data_d  = '0;
      valid_d = '0;
    end
    full_d = &valid_d;
    done_d = full_d && !full_q;
    err_d  = wr_en && !clear && !accept_c;
  end

`ifdef DEMUX_AUTO_INC_EN
  always_comb begin
    ptr_d     = ptr_q;
    ptr_end_d = ptr_end_q;
    if (accept_c) begin
      if (ptr_q == sel_len'(output_size - 1)) begin
        ptr_end_d = 1'b1;
      end else begin
        ptr_d = ptr_q + sel_len'(1);
      end
    end
    if (clear) begin
      ptr_d     = '0;
      ptr_end_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      ptr_end_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      ptr_end_q <= ptr_end_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign demux_out = data_q;
  assign valid     = valid_q;
  assign full      = full_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_demux_reg_loader.sv
// Directed bench for demux_reg_loader at 8/4/2; auto-increment steps run when DEMUX_AUTO_INC_EN is defined.
module tb_demux_reg_loader;

  logic        clk = 1'b0;
  logic        rst, clear, wr_en;
  logic [1:0]  wr_sel;
  logic [7:0]  din;
  logic [31:0] demux_out;
  logic [3:0]  valid;
  logic        full, done, err;

  int checks = 0;
  int passed = 0;
  int done_cnt;

  demux_reg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .din      (din),
    .demux_out(demux_out),
    .valid    (valid),
    .full     (full),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] d);
    wr_en  = 1'b1;
    wr_sel = s;
    din    = d;
    step();
  endtask

  task automatic idle();
    wr_en = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b1; wr_sel = 2'd0; din = 8'hFF;
    step();
    step();
    check("rst_out",   demux_out, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_full",  32'(full), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    rst = 1'b0;
    idle();

`ifndef DEMUX_AUTO_INC_EN
    // Addressed fill in scrambled order
    wr(2'd3, 8'hA0);
    wr(2'd1, 8'hA1);
    wr(2'd0, 8'hA2);
    check("fill3_valid", 32'(valid), 32'hB);
    check("fill3_full",  32'(full), 32'h0);
    check("fill3_done",  32'(done), 32'h0);
    wr(2'd2, 8'hA3);
    check("fill_out",   demux_out, 32'hA2A1A3A0);
    check("fill_valid", 32'(valid), 32'hF);
    check("fill_full",  32'(full), 32'h1);
    check("fill_done",  32'(done), 32'h1);
    check("fill_err",   32'(err), 32'h0);
    idle();
    check("fill_done_drop", 32'(done), 32'h0);
    check("fill_full_hold", 32'(full), 32'h1);
    check("fill_out_hold",  demux_out, 32'hA2A1A3A0);

    // Clear beats a simultaneous write
    clear = 1'b1;
    idle();
    clear = 1'b0;
    wr(2'd1, 8'h55);
    check("clr_pre_out", demux_out, 32'h00550000);
    check("clr_pre_valid", 32'(valid), 32'h2);
    clear = 1'b1;
    wr(2'd2, 8'h77);
    clear = 1'b0;
    check("clr_out",   demux_out, 32'h0);
    check("clr_valid", 32'(valid), 32'h0);
    check("clr_err",   32'(err), 32'h0);
    check("clr_full",  32'(full), 32'h0);

    // Rewrite of a valid slot while full
    wr(2'd0, 8'hB0);
    wr(2'd1, 8'hB1);
    wr(2'd2, 8'hB2);
    wr(2'd3, 8'hB3);
    check("rw_fill_done", 32'(done), 32'h1);
    wr(2'd0, 8'h11);
    check("rw_out",  demux_out, 32'h11B1B2B3);
    check("rw_full", 32'(full), 32'h1);
    check("rw_done", 32'(done), 32'h0);
    check("rw_err",  32'(err), 32'h0);

    // Reset mid-fill, then a fresh fill yields a single done
    clear = 1'b1;
    idle();
    clear = 1'b0;
    wr(2'd0, 8'hEE);
    wr(2'd1, 8'hDD);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("mid_rst_out",   demux_out, 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), 8'(i + 1));
      if (done) done_cnt++;
    end
    idle();
    if (done) done_cnt++;
    check("mid_out",   demux_out, 32'h01020304);
    check("mid_dones", 32'(done_cnt), 32'h1);
    check("mid_full",  32'(full), 32'h1);
`else
    // Auto-increment: wr_sel ignored, fifth write rejected
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      wr(2'd3, 8'(8'h10 + i));
      if (i < 3) check("auto_nodone", 32'(done), 32'h0);
    end
    check("auto_out",  demux_out, 32'h10111213);
    check("auto_done", 32'(done), 32'h1);
    check("auto_full", 32'(full), 32'h1);
    check("auto_err4", 32'(err), 32'h0);
    wr(2'd3, 8'h14);
    check("auto_err5",  32'(err), 32'h1);
    check("auto_out5",  demux_out, 32'h10111213);
    check("auto_done5", 32'(done), 32'h0);
    idle();
    check("auto_err_drop", 32'(err), 32'h0);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    wr(2'd2, 8'h99);
    check("auto_clr_out",   demux_out, 32'h99000000);
    check("auto_clr_valid", 32'(valid), 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
